game_binary_quiz_rounds: RTL and testbench
==========================================

Name: game_binary_quiz_rounds

Overview:
- Parametrised successor of the binary quiz game: shows an NUM_BITS-bit random target MSB-first on one 7-seg digit, one bit per interval, with a blank gap between bits.
- Then shows '?' and waits for the answer button; a match is scored.
- Plays ROUNDS rounds per game, shows the final score, then returns to idle.
- Sits between the button debouncers/random source and the 7-seg decoder in the game top level.

Parameters:
- NUM_BITS, 3, target width; legal range 2..4; answer buttons = 2**NUM_BITS-1.
- ROUNDS, 4, rounds per game; legal range 1..9.
- DELAY_TIME, 10_000_000, cycles each bit / result / score is displayed (1 s at 10 MHz).
- GAP_TIME, 2_000_000, cycles of blank display between consecutive bits.
- COUNTER_LEN, 24, timer width; must hold max(DELAY_TIME, 4*DELAY_TIME when timeout enabled).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- btn  in  2**NUM_BITS-1  debounced, synchronised buttons; btn[i] answers value i+1.
- rnd  in  4  free-running random nibble from random_digit.
- value  out  4  display code: 0/1 bit, 0..9 score, 10 correct, 11 error, 12 blank, 13 '?'.
- score  out  4  correct answers in the current game.
- busy  out  1  high in every state except WAIT.

Behaviour:
- Reset (async, any time, including mid-game): state=WAIT, value=12, score=0, round=0, bit index=0, timer=0, button history=0, busy=0.
- value, score and busy are registered and updated on the same edge as the state transition; value always shows the code of the current state.
- Button events: btn_prev is registered every cycle; press = btn & ~btn_prev (rising edge only).
  - A button held across a state change never answers.
  - With simultaneous edges, the lowest index wins.
- Target: t = rnd[NUM_BITS-1:0], sampled on the edge leaving WAIT or RESULT into the next round; if t==0, use 1.
- States:
  - WAIT: value=12, score=0, round=0. Any press goes to SHOW, bit index = NUM_BITS-1.
  - SHOW: value = target[bit index]. After DELAY_TIME cycles: if bit index==0 go to QUIZ, else go to GAP and decrement the index.
  - GAP: value=12. After GAP_TIME cycles go to SHOW.
  - QUIZ: value=13; waits for a press.
    - Press index+1 == target: go to RESULT, value=10, score+1.
    - Otherwise: go to RESULT, value=11.
  - RESULT: hold value for DELAY_TIME cycles, then round+1.
    - If round+1 == ROUNDS: go to SCORE.
    - Else go to SHOW with a new target.
  - SCORE: value = score. After DELAY_TIME cycles go to WAIT; score stays valid until WAIT clears it on the next edge.
  - Illegal encoding: go to WAIT.
- Timer: cleared on every state entry and incremented each cycle. A timed state lasts exactly its configured cycle count; transition happens when timer == count-1.
- Presses in SHOW, GAP, RESULT and SCORE are ignored.

Optional Feature:
- Macro QUIZ_TIMEOUT_EN.
- Defined: QUIZ counts cycles; at 4*DELAY_TIME cycles with no press, go to RESULT with value=11 (counts as an error, no score). A press in the final timeout cycle takes precedence over the timeout.
- Undefined: QUIZ waits indefinitely; no timeout logic is synthesised.

Decomposition:
- Package game_pkg: display code constants (DISP_CORRECT=10, DISP_ERROR=11, DISP_BLANK=12, DISP_QUESTION=13) and the state encoding localparams, shared with the other games.
- Sub-module btn_edge_detect (parametrised width; registers the previous value and outputs rising-edge pulses), reusable by the other games.
- The random_digit instance stays in the top level.

Test Plan (NUM_BITS=3, ROUNDS=2, DELAY_TIME=4, GAP_TIME=2):
- Reset, idle 10 cycles -> value=12, busy=0, score=0; press btn[0] -> SHOW, busy=1.
- rnd=5, start game -> value sequence 1(4 cycles), 12(2), 0(4), 12(2), 1(4), then 13.
- In QUIZ, pulse btn[4] (answer 5) -> value=10 for 4 cycles, score=1. Round 2 with rnd=0 (target 1): press btn[2] -> value=11, score stays 1, then SCORE shows value=1 for 4 cycles, then WAIT with value=12.
- Hold btn[4] continuously from SHOW into QUIZ -> no answer registered, value stays 13. Release then re-press -> answer accepted.
- Rising edges on btn[0] and btn[4] in the same cycle in QUIZ (target 1) -> btn[0] wins, value=10.
- Assert reset during GAP of round 2 -> next cycle value=12, score=0, busy=0. With QUIZ_TIMEOUT_EN, no press in QUIZ for 16 cycles -> value=11.

Source files
------------

// File: rtl/game_pkg.sv
// Shared display codes and FSM state encoding for the 7-segment quiz games.
package game_pkg;

  localparam logic [3:0] DISP_CORRECT  = 4'd10;
  localparam logic [3:0] DISP_ERROR    = 4'd11;
  localparam logic [3:0] DISP_BLANK    = 4'd12;
  localparam logic [3:0] DISP_QUESTION = 4'd13;

  localparam logic [2:0] S_WAIT   = 3'd0;
  localparam logic [2:0] S_SHOW   = 3'd1;
  localparam logic [2:0] S_GAP    = 3'd2;
  localparam logic [2:0] S_QUIZ   = 3'd3;
  localparam logic [2:0] S_RESULT = 3'd4;
  localparam logic [2:0] S_SCORE  = 3'd5;

  typedef enum logic [2:0] {
    ST_WAIT   = S_WAIT,
    ST_SHOW   = S_SHOW,
    ST_GAP    = S_GAP,
    ST_QUIZ   = S_QUIZ,
    ST_RESULT = S_RESULT,
    ST_SCORE  = S_SCORE
  } state_t;

endpackage

// File: rtl/btn_edge_detect.sv
// Rising-edge detector for a bank of debounced, synchronised buttons.
module btn_edge_detect #(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_btn,
  output logic [WIDTH-1:0] o_press
);

  logic [WIDTH-1:0] r_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_prev <= '0;
    else       r_prev <= i_btn;
  end

  assign o_press = i_btn & ~r_prev;

endmodule

// File: rtl/game_binary_quiz_rounds.sv
// Multi-round binary quiz: flashes a random target MSB-first, then scores the answer button.
// Define QUIZ_TIMEOUT_EN to turn an unanswered question into an error after 4*DELAY_TIME cycles.
module game_binary_quiz_rounds
  import game_pkg::*;
#(
  parameter int NUM_BITS    = 3,
  parameter int ROUNDS      = 4,
  parameter int DELAY_TIME  = 10_000_000,
  parameter int GAP_TIME    = 2_000_000,
  parameter int COUNTER_LEN = 24
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [2**NUM_BITS-2:0] btn,
  input  logic [3:0]             rnd,
  output logic [3:0]             value,
  output logic [3:0]             score,
  output logic                   busy
);

  localparam int NBTN  = 2**NUM_BITS - 1;
  localparam int BIT_W = $clog2(NUM_BITS);
  localparam logic [COUNTER_LEN-1:0] DELAY_LAST = COUNTER_LEN'(DELAY_TIME - 1);
  localparam logic [COUNTER_LEN-1:0] GAP_LAST   = COUNTER_LEN'(GAP_TIME - 1);
`ifdef QUIZ_TIMEOUT_EN
  localparam logic [COUNTER_LEN-1:0] TIMEOUT_LAST = COUNTER_LEN'(4 * DELAY_TIME - 1);
`endif

  state_t                 r_state;
  logic [COUNTER_LEN-1:0] r_timer;
  logic [NUM_BITS-1:0]    r_target;
  logic [BIT_W-1:0]       r_bit;
  logic [3:0]             r_round;

  logic [NBTN-1:0]     w_press;
  logic                w_any;
  logic [NUM_BITS-1:0] w_answer;
  logic [NUM_BITS-1:0] w_new_target;
  logic                w_unused_rnd;

  btn_edge_detect #(.WIDTH(NBTN)) u_btn_edge (
    .clk     (clk),
    .reset   (reset),
    .i_btn   (btn),
    .o_press (w_press)
  );

  // Scan from the top down so the lowest pressed index is the one left standing.
  always_comb begin
    w_answer = '0;
    for (int i = NBTN - 1; i >= 0; i--) begin
      if (w_press[i]) w_answer = NUM_BITS'(i + 1);
    end
  end

  assign w_any        = |w_press;
  assign w_new_target = (rnd[NUM_BITS-1:0] == '0) ? NUM_BITS'(1) : rnd[NUM_BITS-1:0];
  assign w_unused_rnd = ^rnd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_WAIT;
      r_timer  <= '0;
      r_target <= '0;
      r_bit    <= '0;
      r_round  <= '0;
      value    <= DISP_BLANK;
      score    <= '0;
      busy     <= 1'b0;
    end else begin
      r_timer <= r_timer + 1'b1;
      case (r_state)
        ST_WAIT: begin
          value   <= DISP_BLANK;
          score   <= '0;
          r_round <= '0;
          busy    <= 1'b0;
          if (w_any) begin
            r_state  <= ST_SHOW;
            r_timer  <= '0;
            r_target <= w_new_target;
            r_bit    <= BIT_W'(NUM_BITS - 1);
            value    <= {3'b000, w_new_target[NUM_BITS-1]};
            busy     <= 1'b1;
          end
        end
        ST_SHOW: begin
          if (r_timer == DELAY_LAST) begin
            r_timer <= '0;
            if (r_bit == '0) begin
              r_state <= ST_QUIZ;
              value   <= DISP_QUESTION;
            end else begin
              r_state <= ST_GAP;
              r_bit   <= r_bit - 1'b1;
              value   <= DISP_BLANK;
            end
          end
        end
        ST_GAP: begin
          if (r_timer == GAP_LAST) begin
            r_state <= ST_SHOW;
            r_timer <= '0;
            value   <= {3'b000, r_target[r_bit]};
          end
        end
        ST_QUIZ: begin
          if (w_any) begin
            r_state <= ST_RESULT;
            r_timer <= '0;
            if (w_answer == r_target) begin
              value <= DISP_CORRECT;
              score <= score + 4'd1;
            end else begin
              value <= DISP_ERROR;
            end
          end
`ifdef QUIZ_TIMEOUT_EN
          else if (r_timer == TIMEOUT_LAST) begin
            r_state <= ST_RESULT;
            r_timer <= '0;
            value   <= DISP_ERROR;
          end
`endif
        end
        ST_RESULT: begin
          if (r_timer == DELAY_LAST) begin
            r_timer <= '0;
            r_round <= r_round + 4'd1;
            if (r_round + 4'd1 == 4'(ROUNDS)) begin
              r_state <= ST_SCORE;
              value   <= score;
            end else begin
              r_state  <= ST_SHOW;
              r_target <= w_new_target;
              r_bit    <= BIT_W'(NUM_BITS - 1);
              value    <= {3'b000, w_new_target[NUM_BITS-1]};
            end
          end
        end
        ST_SCORE: begin
          if (r_timer == DELAY_LAST) begin
            r_state <= ST_WAIT;
            r_timer <= '0;
            value   <= DISP_BLANK;
            busy    <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_WAIT;
          r_timer <= '0;
          value   <= DISP_BLANK;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_binary_quiz_rounds.sv
// Bench for game_binary_quiz_rounds: directed game scenarios plus randomized games vs a display-sequence model.
module tb_game_binary_quiz_rounds;

  localparam int NUM_BITS = 3;
  localparam int ROUNDS   = 2;
  localparam int DELAY    = 4;
  localparam int GAP      = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] btn = '0;
  logic [3:0] rnd = '0;
  logic [3:0] value;
  logic [3:0] score;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;
  int m_target;
  int m_score;
  int m_round;

  always #5 clk = ~clk;

  game_binary_quiz_rounds #(
    .NUM_BITS    (NUM_BITS),
    .ROUNDS      (ROUNDS),
    .DELAY_TIME  (DELAY),
    .GAP_TIME    (GAP),
    .COUNTER_LEN (24)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .btn   (btn),
    .rnd   (rnd),
    .value (value),
    .score (score),
    .busy  (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int tgt(input logic [3:0] r);
    int t;
    t = int'(r) % 8;
    if (t == 0) t = 1;
    return t;
  endfunction

  // Expect the display to hold one code for n cycles while in a game; optionally jiggle buttons.
  task automatic expect_seq(input string tag, input int code, input int n, input bit noise);
    for (int i = 0; i < n; i++) begin
      if (noise) btn = 7'($urandom);
      chk(tag, 32'(value), code);
      chk({tag, "_busy"}, 32'(busy), 1);
      @(negedge clk);
    end
  endtask

  task automatic start_game(input logic [3:0] r, input int idx);
    rnd = r;
    btn = 7'(1 << idx);
    @(negedge clk);
    btn = '0;
    m_target = tgt(r);
    m_score  = 0;
    m_round  = 0;
  endtask

  task automatic show_bits(input bit noise, input logic [6:0] hold);
    for (int b = NUM_BITS - 1; b >= 0; b--) begin
      if (b == 0 && hold != '0) begin
        btn = hold;
        expect_seq("bit", (m_target >> b) & 1, DELAY, 1'b0);
      end else begin
        expect_seq("bit", (m_target >> b) & 1, DELAY, noise);
      end
      if (b > 0) expect_seq("gap", 12, GAP, noise);
    end
  endtask

  task automatic answer_round(input logic [6:0] ans, input logic [3:0] next_rnd, input bit held);
    int a;
    bit ok;
    if (held) begin
      expect_seq("held_quiz", 13, 3, 1'b0);
      btn = '0;
      expect_seq("released", 13, 1, 1'b0);
    end else begin
      btn = '0;
      expect_seq("quiz", 13, 1 + int'($urandom_range(0, 2)), 1'b0);
    end
    btn = ans;
    @(negedge clk);
    btn = '0;
    a = 0;
    for (int i = 6; i >= 0; i--) if (ans[i]) a = i + 1;
    ok = (a == m_target);
    if (ok) m_score++;
    chk("score", 32'(score), m_score);
    rnd = next_rnd;
    if (ok) expect_seq("correct", 10, DELAY, 1'b0);
    else    expect_seq("error", 11, DELAY, 1'b0);
    m_round++;
    if (m_round == ROUNDS) begin
      expect_seq("final_score", m_score, DELAY, 1'b0);
      chk("end_value", 32'(value), 12);
      chk("end_busy", 32'(busy), 0);
      @(negedge clk);
      chk("end_score", 32'(score), 0);
      m_round = 0;
      m_score = 0;
    end else begin
      m_target = tgt(next_rnd);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] ans;
    repeat (3) @(negedge clk);
    chk("reset_value", 32'(value), 12);
    chk("reset_score", 32'(score), 0);
    chk("reset_busy", 32'(busy), 0);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("idle_value", 32'(value), 12);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_score", 32'(score), 0);

    // Directed game: target 5 answered right, then target 1 answered with 3.
    start_game(4'd5, 0);
    show_bits(1'b0, '0);
    answer_round(7'b0010000, 4'd0, 1'b0);
    show_bits(1'b0, '0);
    answer_round(7'b0000100, 4'd5, 1'b0);

    // Button held into QUIZ must not answer; a fresh press does.
    start_game(4'd5, 3);
    show_bits(1'b0, 7'b0010000);
    answer_round(7'b0010000, 4'd0, 1'b1);
    // Simultaneous edges: lowest index wins on target 1.
    show_bits(1'b0, '0);
    answer_round(7'b0010001, 4'd3, 1'b0);

    // Randomized games with button noise during the display phases.
    repeat (6) begin
      start_game(4'($urandom), int'($urandom_range(0, 6)));
      repeat (ROUNDS) begin
        show_bits(1'($urandom), '0);
        if ($urandom_range(0, 1) == 1) ans = 7'(1 << (m_target - 1));
        else ans = 7'($urandom_range(1, 127));
        answer_round(ans, 4'($urandom), 1'b0);
      end
    end

    // Asynchronous reset in the middle of round 2's gap.
    start_game(4'd7, 2);
    show_bits(1'b0, '0);
    answer_round(7'b1000000, 4'($urandom), 1'b0);
    expect_seq("bit", (m_target >> 2) & 1, DELAY, 1'b0);
    expect_seq("gap", 12, 1, 1'b0);
    reset = 1'b1;
    #1;
    chk("async_rst_value", 32'(value), 12);
    chk("async_rst_score", 32'(score), 0);
    chk("async_rst_busy", 32'(busy), 0);
    @(negedge clk);
    chk("rst_value", 32'(value), 12);
    chk("rst_score", 32'(score), 0);
    chk("rst_busy", 32'(busy), 0);
    reset = 1'b0;
    @(negedge clk);

    // Unanswered question.
    start_game(4'($urandom), 0);
    show_bits(1'b0, '0);
    btn = '0;
`ifdef QUIZ_TIMEOUT_EN
    expect_seq("timeout_wait", 13, 16, 1'b0);
    expect_seq("timeout", 11, DELAY, 1'b0);
    chk("timeout_score", 32'(score), 0);
`else
    expect_seq("no_timeout", 13, 24, 1'b0);
`endif
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("final_value", 32'(value), 12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
